// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-mode constants and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Unused upper bits must be zero so the XOR covers only the real word.
  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Bit_End
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign o_Bit_End = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (i_Clear || o_Bit_End) cnt_d = '0;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter, LSB first, STOP_BITS stop bits.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic [1:0]           i_Parity_Mode,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  // state  | meaning
  // IDLE   | line high, ready for a word (Done pulses here after a frame)
  // START  | line low for one bit period
  // DATA   | data bits, LSB first
  // PARITY | parity bit (only with parity build and mode even/odd)
  // STOP   | line high for STOP_BITS bit periods

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 serial_q, serial_d;
  logic                 ready_q, ready_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 bit_end;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_Parity_Mode;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .i_Clock   (i_Clock),
    .i_Reset   (i_Reset),
    .i_Clear   (state_q == IDLE),
    .o_Bit_End (bit_end)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    serial_d = serial_q;
    ready_d  = ready_q;
    active_d = active_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
        if (i_Tx_DV) begin
          state_d  = START;
          data_d   = i_Tx_Byte;
          idx_d    = '0;
          stop_d   = 1'b0;
          serial_d = 1'b0;
          ready_d  = 1'b0;
          active_d = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_en_d  = (i_Parity_Mode == PAR_EVEN) || (i_Parity_Mode == PAR_ODD);
          par_bit_d = calc_parity(8'(i_Tx_Byte), i_Parity_Mode == PAR_ODD);
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = data_q[0];
          data_d   = data_q >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
            state_d  = STOP;
            serial_d = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d  = PARITY;
              serial_d = par_bit_q;
            end
`endif
          end else begin
            idx_d    = idx_q + IW'(1);
            serial_d = data_q[0];
            data_d   = data_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d  = STOP;
          serial_d = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_q == LAST_STOP) begin
            state_d  = IDLE;
            ready_d  = 1'b1;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        ready_d  = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      serial_q <= 1'b1;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      serial_q <= serial_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule
